alu_scheduler: RTL and testbench
================================

# alu_scheduler

Sequencer and round-robin arbiter sharing one 4-bit logic/arithmetic datapath (AND, OR, XOR, 4-bit full adder, 4:1 result mux) among four requesters. Each requester presents an opcode, operands and carry-in with a valid/ready handshake. The block grants one requester, registers its operands, runs the shared datapath for one cycle and returns a tagged result through a valid/ready response port. It sits between the requesting units and the shared datapath and is the only driver of that datapath's inputs and mux select.

## Interface

- WIDTH, 4, operand/result width. Only 4 is supported.
- N_REQ, 4, number of requesters. Fixed at 4 because the requester id is 2 bits.

- clk  in  1  rising-edge clock
- reset_L  in  1  asynchronous, active-low reset
- req_valid  in  4  per-requester request valid
- req_op  in  8  2 bits per requester, requester i at [2i+1:2i]: 00 AND, 01 OR, 10 XOR, 11 ADD
- req_a  in  16  operand A, requester i at [4i+3:4i]
- req_b  in  16  operand B, same packing as req_a
- req_cin  in  4  carry-in per requester; used only for ADD
- req_ready  out  4  one-hot grant; handshake when req_valid[i] & req_ready[i]
- rsp_valid  out  1  result available
- rsp_id  out  2  index of the requester that owns the result
- rsp_data  out  4  result
- rsp_cout  out  1  adder carry-out; 0 for non-ADD ops
- rsp_ready  in  1  consumer accepts the result
- busy  out  1  high whenever state is not IDLE
- ops_done  out  8  count of completed responses

## Operation

- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Winner = first i with req_valid[i] set, searching ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - req_ready = one-hot(winner), driven combinationally. req_ready = 0 if no request is valid.
  - On the handshake edge: capture op, a, b, cin and id into internal registers. Set ptr = winner+1 mod 4. Move to EXEC.
- EXEC:
  - The datapath is driven from the captured registers; the mux select equals the captured op.
  - Result register loads on the next edge. Move to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid = 1, with rsp_id, rsp_data and rsp_cout stable.
  - Stay in RESP while rsp_ready = 0.
  - On an edge with rsp_ready = 1: move to IDLE and increment ops_done (wraps 255 -> 0).
  - req_ready = 0.
- Arithmetic:
  - ADD: 5-bit sum = a + b + cin; rsp_data = sum[3:0]; rsp_cout = sum[4].
  - AND/OR/XOR: bitwise; rsp_cout = 0; cin ignored.
- Requests are sampled only in IDLE. A requester may drop req_valid before it is granted; nothing is latched for it.
- Pointer rule: ptr changes only on a grant. Reset value is 0.

## Timing

- Reset (asynchronous, immediate): state = IDLE, ptr = 0, req_ready = 0, rsp_valid = 0, rsp_id = 0, rsp_data = 0, rsp_cout = 0, busy = 0, ops_done = 0. Captured registers clear to 0.
- Reset asserted mid-EXEC or mid-RESP: the transaction is dropped and no response is issued. After release, the first grant goes to the lowest valid index starting from 0.
- Latency: handshake on edge T; rsp_valid is high in the cycle after edge T+1. With rsp_ready held high the response is consumed at edge T+2 and IDLE can grant again at edge T+3.
- Peak throughput is one operation per 3 cycles.
- Response outputs hold constant while rsp_valid = 1 and rsp_ready = 0.
- req_valid changes during EXEC/RESP have no effect.
- A single requester valid continuously is granted every 3 cycles (with rsp_ready = 1). No starvation: each requester waits at most 3 grants.

## Test plan

- Reset, then requester 0 only: AND a=1, b=E -> grant req_ready=0001; rsp_data=0, rsp_cout=0, rsp_id=0 two edges later.
- Requester 2: ADD a=E, b=1, cin=1 -> rsp_data=0, rsp_cout=1. Then ADD a=F, b=F, cin=0 -> rsp_data=E, rsp_cout=1. Then XOR a=1, b=E -> rsp_data=F, rsp_cout=0.
- All four req_valid held high, rsp_ready=1 -> grants in order 0, 1, 2, 3, 0 at 3-cycle spacing; ops_done increments by 1 per response.
- rsp_ready held 0 for 5 cycles in RESP -> rsp_valid stays 1, outputs unchanged, req_ready=0000, busy=1. Releasing rsp_ready returns the FSM to IDLE on the next edge.
- reset_L pulsed low during EXEC of requester 3 -> outputs go to reset values immediately and no response appears. Next grant with req_valid=1010 goes to requester 1 (ptr=0).
- 256 completed ADD operations -> ops_done wraps to 0. OR a=5, b=A -> rsp_data=F, with cin=1 ignored (rsp_cout=0).

Source files
------------

// File: rtl/alu_scheduler.sv
// alu_scheduler: round-robin sequencer sharing one 4-bit logic/add datapath among four requesters
module alu_scheduler #(
    parameter int WIDTH = 4,
    parameter int N_REQ = 4
) (
    input  logic                   clk,
    input  logic                   reset_L,
    input  logic [N_REQ-1:0]       req_valid,
    input  logic [2*N_REQ-1:0]     req_op,
    input  logic [WIDTH*N_REQ-1:0] req_a,
    input  logic [WIDTH*N_REQ-1:0] req_b,
    input  logic [N_REQ-1:0]       req_cin,
    output logic [N_REQ-1:0]       req_ready,
    output logic                   rsp_valid,
    output logic [1:0]             rsp_id,
    output logic [WIDTH-1:0]       rsp_data,
    output logic                   rsp_cout,
    input  logic                   rsp_ready,
    output logic                   busy,
    output logic [7:0]             ops_done
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
    state_t state, state_nx;
    logic [1:0] ptr, winner, cap_op, cap_id;
    logic found, hs, cap_cin, res_cout, alu_cout;
    logic [WIDTH-1:0] cap_a, cap_b, res_data, alu;
    logic [WIDTH:0] sum;
    always_comb begin
        winner = ptr;
        found = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (req_valid[ptr + 2'(k)]) begin
                winner = ptr + 2'(k);
                found = 1'b1;
            end
        end
    end
    assign req_ready = (state == IDLE && found && reset_L) ? 4'b0001 << winner : '0;
    assign hs = |(req_valid & req_ready);
    always_comb begin
        state_nx = state == IDLE ? (hs ? EXEC : IDLE) :
                   state == EXEC ? RESP : (rsp_ready ? IDLE : RESP);
    end
    assign sum = {1'b0, cap_a} + {1'b0, cap_b} + {{WIDTH{1'b0}}, cap_cin};
    assign alu = cap_op == 2'b00 ? cap_a & cap_b :
                 cap_op == 2'b01 ? cap_a | cap_b :
                 cap_op == 2'b10 ? cap_a ^ cap_b : sum[WIDTH-1:0];
    assign alu_cout = cap_op == 2'b11 && sum[WIDTH];
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state <= IDLE;
            ptr <= '0;
            cap_op <= '0;
            cap_id <= '0;
            cap_a <= '0;
            cap_b <= '0;
            cap_cin <= 1'b0;
            res_data <= '0;
            res_cout <= 1'b0;
            ops_done <= '0;
        end else begin
            state <= state_nx;
            if (hs) begin
                cap_op <= req_op[{winner, 1'b0} +: 2];
                cap_a <= req_a[{winner, 2'b00} +: WIDTH];
                cap_b <= req_b[{winner, 2'b00} +: WIDTH];
                cap_cin <= req_cin[winner];
                cap_id <= winner;
                ptr <= winner + 2'd1;
            end
            if (state == EXEC) begin
                res_data <= alu;
                res_cout <= alu_cout;
            end
            if (state == RESP && rsp_ready) ops_done <= ops_done + 8'd1;
        end
    end
    assign rsp_valid = state == RESP;
    assign busy = state != IDLE;
    assign rsp_id = cap_id;
    assign rsp_data = res_data;
    assign rsp_cout = res_cout;
endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler: directed vectors for alu_scheduler
module tb_alu_scheduler;
    logic clk = 1'b0, reset_L = 1'b0;
    logic [3:0] req_valid = '0, req_cin = '0, req_ready;
    logic [7:0] req_op = '0, ops_done;
    logic [15:0] req_a = '0, req_b = '0;
    logic rsp_valid, rsp_cout, rsp_ready = 1'b0, busy;
    logic [1:0] rsp_id;
    logic [3:0] rsp_data;
    int checks = 0, errors = 0, exp_ops = 0;
    alu_scheduler dut (
        .clk(clk), .reset_L(reset_L), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_cin(req_cin), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_cout(rsp_cout),
        .rsp_ready(rsp_ready), .busy(busy), .ops_done(ops_done)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask
    task automatic do_reset();
        @(negedge clk);
        reset_L = 1'b0;
        #1;
        check("rst_ready", req_ready, 0);
        check("rst_valid", rsp_valid, 0);
        check("rst_id", rsp_id, 0);
        check("rst_data", rsp_data, 0);
        check("rst_cout", rsp_cout, 0);
        check("rst_busy", busy, 0);
        check("rst_ops", ops_done, 0);
        @(negedge clk);
        reset_L = 1'b1;
        exp_ops = 0;
    endtask
    task automatic do_op(input int id, input logic [1:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic cin, input logic [3:0] ed, input logic ec);
        @(negedge clk);
        req_valid = '0;
        req_valid[id] = 1'b1;
        req_op[2*id +: 2] = op;
        req_a[4*id +: 4] = a;
        req_b[4*id +: 4] = b;
        req_cin[id] = cin;
        rsp_ready = 1'b1;
        #1 check("grant", req_ready, 32'(1) << id);
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        check("exec_busy", busy, 1);
        check("exec_valid", rsp_valid, 0);
        @(posedge clk);
        @(negedge clk);
        check("rsp_valid", rsp_valid, 1);
        check("rsp_id", rsp_id, id);
        check("rsp_data", rsp_data, ed);
        check("rsp_cout", rsp_cout, ec);
        check("ops_before", ops_done, exp_ops);
        @(posedge clk);
        exp_ops = (exp_ops + 1) % 256;
        @(negedge clk);
        check("idle_valid", rsp_valid, 0);
        check("idle_busy", busy, 0);
        check("ops_after", ops_done, exp_ops);
    endtask
    initial begin
        logic [7:0] iv;
        logic [4:0] s;
        do_reset();
        do_op(0, 2'b00, 4'h1, 4'hE, 1'b0, 4'h0, 1'b0);
        do_op(2, 2'b11, 4'hE, 4'h1, 1'b1, 4'h0, 1'b1);
        do_op(2, 2'b11, 4'hF, 4'hF, 1'b0, 4'hE, 1'b1);
        do_op(2, 2'b10, 4'h1, 4'hE, 1'b1, 4'hF, 1'b0);
        do_reset();
        @(negedge clk);
        req_valid = 4'b1111;
        req_op = 8'hFF;
        req_a = 16'h4321;
        req_b = '0;
        req_cin = '0;
        rsp_ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            #1 check("rr_grant", req_ready, 32'(1) << (g % 4));
            @(posedge clk);
            @(negedge clk);
            @(posedge clk);
            @(negedge clk);
            check("rr_id", rsp_id, g % 4);
            check("rr_data", rsp_data, g % 4 + 1);
            check("rr_ops", ops_done, exp_ops);
            @(posedge clk);
            exp_ops++;
            @(negedge clk);
        end
        req_valid = '0;
        do_reset();
        @(negedge clk);
        req_valid = 4'b0010;
        req_op[3:2] = 2'b01;
        req_a[7:4] = 4'h3;
        req_b[7:4] = 4'h4;
        rsp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 4'b1111;
        @(posedge clk);
        @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            check("stall_valid", rsp_valid, 1);
            check("stall_data", rsp_data, 4'h7);
            check("stall_id", rsp_id, 1);
            check("stall_ready", req_ready, 0);
            check("stall_busy", busy, 1);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("stall_done", busy, 0);
        check("stall_ops", ops_done, 1);
        check("stall_next_grant", req_ready, 4'b0100);
        req_valid = '0;
        do_reset();
        @(negedge clk);
        req_valid = 4'b1000;
        req_op[7:6] = 2'b11;
        req_a[15:12] = 4'h7;
        req_b[15:12] = 4'h8;
        @(posedge clk);
        @(negedge clk);
        check("mid_exec_busy", busy, 1);
        reset_L = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_valid", rsp_valid, 0);
        check("async_ready", req_ready, 0);
        check("async_data", rsp_data, 0);
        req_valid = '0;
        @(posedge clk);
        @(negedge clk);
        reset_L = 1'b1;
        exp_ops = 0;
        @(posedge clk);
        @(negedge clk);
        check("no_rsp", rsp_valid, 0);
        req_valid = 4'b1010;
        #1 check("post_rst_grant", req_ready, 4'b0010);
        req_valid = '0;
        do_op(1, 2'b00, 4'hC, 4'hA, 1'b0, 4'h8, 1'b0);
        do_reset();
        for (int i = 0; i < 256; i++) begin
            iv = 8'(i);
            s = {1'b0, iv[3:0]} + {1'b0, iv[7:4]} + {4'b0, iv[0]};
            do_op(i % 4, 2'b11, iv[3:0], iv[7:4], iv[0], s[3:0], s[4]);
        end
        check("wrap", ops_done, 0);
        do_op(1, 2'b01, 4'h5, 4'hA, 1'b1, 4'hF, 1'b0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
